// File: rtl/led_ctrl_pkg.sv
// Shared constants for the LED register load path: FSM encoding and defaults.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package led_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    localparam int          DATA_W_DEF = 4;
    localparam int unsigned HOLD_1S    = 32'd50_000_000;

endpackage

// File: rtl/rr_priority_pick.sv
// Round-robin pick: first set request searching upward from ptr, wrapping mod N.
// Latency: combinational.
// Backpressure: none; the caller decides when to consume the winner.
module rr_priority_pick #(
    parameter int N     = 4,
    parameter int PTR_W = $clog2(N)
) (
    input  logic [N-1:0]     req_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [N-1:0]     winner_o,
    output logic             any_req_o
);

    // Scan N positions starting at ptr; the first hit becomes the one-hot winner.
    always_comb begin
        int  idx;
        logic found;
        winner_o = '0;
        found    = 1'b0;
        for (int i = 0; i < N; i++) begin
            idx = (int'(ptr_i) + i) % N;
            if (!found && req_i[idx]) begin
                winner_o[idx] = 1'b1;
                found         = 1'b1;
            end
        end
    end

    assign any_req_o = |req_i;

endmodule

// File: rtl/led_reg_load_arbiter.sv
// Round-robin arbiter/sequencer that feeds one load pulse per grant into the LED register.
// Latency: request seen in IDLE at edge t -> load_en_o/ack_o high in cycle t+1; loads spaced HOLD_CYCLES+2.
// Backpressure: requests are level and stay pending through LOAD/HOLD until acked.
module led_reg_load_arbiter
    import led_ctrl_pkg::*;
#(
    parameter int              NREQ        = 4,
    parameter int              DATA_W      = DATA_W_DEF,
    parameter longint unsigned HOLD_CYCLES = 64'(HOLD_1S)
) (
    input  logic                     clk50m_i,
    input  logic                     rst_i,
    input  logic [NREQ-1:0]          req_i,
    input  logic [NREQ*DATA_W-1:0]   req_data_i,
    output logic [NREQ-1:0]          ack_o,
    output logic [NREQ-1:0]          grant_o,
    output logic                     load_en_o,
    output logic [DATA_W-1:0]        load_data_o,
    output logic                     busy_o
);

    localparam int PTR_W = $clog2(NREQ);
    localparam int CNT_W = (HOLD_CYCLES == 64'd0) ? 1 : $clog2(HOLD_CYCLES + 64'd1);
    // Reload value for the hold counter; HOLD_CYCLES=0 never enters HOLD.
    localparam logic [CNT_W-1:0] HOLD_RELOAD =
        (HOLD_CYCLES == 64'd0) ? '0 : CNT_W'(HOLD_CYCLES - 64'd1);

    state_e              state_q;
    logic [PTR_W-1:0]    ptr_q;
    logic [PTR_W-1:0]    ptr_d;
    logic [PTR_W-1:0]    win_idx_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [NREQ-1:0]     ack_q;
    logic [NREQ-1:0]     grant_q;
    logic                load_en_q;
    logic [DATA_W-1:0]   load_data_q;
    logic                busy_q;

    logic [NREQ-1:0]     winner;
    logic                any_req;
    logic [PTR_W-1:0]    win_idx;
    logic [DATA_W-1:0]   win_data;

    rr_priority_pick #(
        .N     (NREQ),
        .PTR_W (PTR_W)
    ) u_pick (
        .req_i     (req_i),
        .ptr_i     (ptr_q),
        .winner_o  (winner),
        .any_req_o (any_req)
    );

    // Encode the one-hot winner to an index and mux out its data slice.
    always_comb begin
        win_idx  = '0;
        win_data = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (winner[k]) begin
                win_idx  = PTR_W'(k);
                win_data = req_data_i[k*DATA_W +: DATA_W];
            end
        end
    end

    // Priority moves to the requester just after the last winner, wrapping at NREQ.
    always_comb begin
        ptr_d = (win_idx_q == PTR_W'(NREQ - 1)) ? '0 : win_idx_q + PTR_W'(1);
    end

    // IDLE/LOAD/HOLD sequencer; every output is a register updated here.
    always_ff @(posedge clk50m_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            win_idx_q   <= '0;
            cnt_q       <= '0;
            ack_q       <= '0;
            grant_q     <= '0;
            load_en_q   <= 1'b0;
            load_data_q <= '0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (any_req) begin
                        // Data is frozen here; later changes on req_data_i are ignored.
                        grant_q     <= winner;
                        ack_q       <= winner;
                        win_idx_q   <= win_idx;
                        load_data_q <= win_data;
                        load_en_q   <= 1'b1;
                        busy_q      <= 1'b1;
                        state_q     <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    load_en_q <= 1'b0;
                    ack_q     <= '0;
                    ptr_q     <= ptr_d;
                    if (HOLD_CYCLES == 64'd0) begin
                        grant_q <= '0;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q   <= HOLD_RELOAD;
                        state_q <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (cnt_q == '0) begin
                        grant_q <= '0;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    load_en_q <= 1'b0;
                    ack_q     <= '0;
                    grant_q   <= '0;
                    busy_q    <= 1'b0;
                    state_q   <= ST_IDLE;
                end
            endcase
        end
    end

    assign ack_o       = ack_q;
    assign grant_o     = grant_q;
    assign load_en_o   = load_en_q;
    assign load_data_o = load_data_q;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_led_reg_load_arbiter.sv
// Directed bench for led_reg_load_arbiter with HOLD_CYCLES = 3, 0 and 10 instances.
// Latency: inputs driven on negedge, outputs sampled on the following negedge.
// Backpressure: n/a.
module tb_led_reg_load_arbiter;

    logic clk;
    logic rst;

    // Instance a: HOLD_CYCLES = 3
    logic [3:0]  req_a;
    logic [15:0] dat_a;
    logic [3:0]  ack_a, grant_a, ldat_a;
    logic        len_a, busy_a;
    // Instance b: HOLD_CYCLES = 0
    logic [3:0]  req_b;
    logic [15:0] dat_b;
    logic [3:0]  ack_b, grant_b, ldat_b;
    logic        len_b, busy_b;
    // Instance c: HOLD_CYCLES = 10
    logic [3:0]  req_c;
    logic [15:0] dat_c;
    logic [3:0]  ack_c, grant_c, ldat_c;
    logic        len_c, busy_c;

    int checks = 0;
    int errors = 0;

    led_reg_load_arbiter #(.NREQ(4), .DATA_W(4), .HOLD_CYCLES(64'd3)) u_dut_h3 (
        .clk50m_i (clk), .rst_i (rst), .req_i (req_a), .req_data_i (dat_a),
        .ack_o (ack_a), .grant_o (grant_a), .load_en_o (len_a),
        .load_data_o (ldat_a), .busy_o (busy_a)
    );

    led_reg_load_arbiter #(.NREQ(4), .DATA_W(4), .HOLD_CYCLES(64'd0)) u_dut_h0 (
        .clk50m_i (clk), .rst_i (rst), .req_i (req_b), .req_data_i (dat_b),
        .ack_o (ack_b), .grant_o (grant_b), .load_en_o (len_b),
        .load_data_o (ldat_b), .busy_o (busy_b)
    );

    led_reg_load_arbiter #(.NREQ(4), .DATA_W(4), .HOLD_CYCLES(64'd10)) u_dut_h10 (
        .clk50m_i (clk), .rst_i (rst), .req_i (req_c), .req_data_i (dat_c),
        .ack_o (ack_c), .grant_o (grant_c), .load_en_o (len_c),
        .load_data_o (ldat_c), .busy_o (busy_c)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        int busy_cnt;
        logic seen;
        logic [3:0] exp_ack [5];
        logic [3:0] exp_dat [5];
        exp_ack[0] = 4'b0001; exp_ack[1] = 4'b0010; exp_ack[2] = 4'b0100;
        exp_ack[3] = 4'b1000; exp_ack[4] = 4'b0001;
        exp_dat[0] = 4'h1; exp_dat[1] = 4'h2; exp_dat[2] = 4'h3;
        exp_dat[3] = 4'h4; exp_dat[4] = 4'h1;

        rst   = 1'b1;
        req_a = '0; dat_a = '0;
        req_b = '0; dat_b = '0;
        req_c = '0; dat_c = '0;
        repeat (3) step();
        rst = 1'b0;
        step();

        // Reset values
        chk("rst_len",   32'(len_a),   32'h0);
        chk("rst_ack",   32'(ack_a),   32'h0);
        chk("rst_grant", 32'(grant_a), 32'h0);
        chk("rst_busy",  32'(busy_a),  32'h0);
        chk("rst_ldat",  32'(ldat_a),  32'h0);

        // No requests for 20 cycles: nothing moves
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            seen = seen | len_a | (|ack_a) | (|grant_a) | busy_a | (|ldat_a);
        end
        chk("idle_quiet", 32'(seen), 32'h0);

        // Single request from requester 2, data A; HOLD_CYCLES=3
        req_a = 4'b0100; dat_a = 16'h0A00;
        step();
        chk("r2_len",   32'(len_a),   32'h1);
        chk("r2_ldat",  32'(ldat_a),  32'hA);
        chk("r2_ack",   32'(ack_a),   32'b0100);
        chk("r2_grant", 32'(grant_a), 32'b0100);
        req_a = 4'b0000;
        busy_cnt = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            if (busy_a) busy_cnt++;
            chk("r2_hold_len", 32'(len_a), 32'h0);
        end
        step();
        chk("r2_busy_cnt", 32'(busy_cnt), 32'd4);
        chk("r2_idle_busy",  32'(busy_a),  32'h0);
        chk("r2_idle_grant", 32'(grant_a), 32'h0);

        // All four requesting, HOLD_CYCLES=0: strict rotation every 2 cycles
        req_b = 4'b1111; dat_b = 16'h4321;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("rot_len",  32'(len_b),  32'h1);
            chk("rot_ack",  32'(ack_b),  32'(exp_ack[i]));
            chk("rot_ldat", 32'(ldat_b), 32'(exp_dat[i]));
            step();
            chk("rot_gap",  32'(len_b),  32'h0);
            if (i == 4) req_b = 4'b0000;
        end

        // Requester 1 drops req the cycle after arbitration; load still goes out
        req_b = 4'b0010; dat_b = 16'h0050;
        step();
        req_b = 4'b0000; dat_b = 16'h0000;
        chk("drop_len",  32'(len_b),  32'h1);
        chk("drop_ldat", 32'(ldat_b), 32'h5);
        chk("drop_ack",  32'(ack_b),  32'b0010);
        step();
        chk("drop_after_len", 32'(len_b), 32'h0);
        step();
        chk("drop_no_reload", 32'(len_b), 32'h0);

        // Request arrives during HOLD; data edited mid-HOLD is what gets loaded
        req_a = 4'b0100; dat_a = 16'h0B00;
        step();
        chk("mid_first_ack", 32'(ack_a), 32'b0100);
        req_a = 4'b0001; dat_a = 16'h0003;
        step();
        chk("mid_hold1_len", 32'(len_a), 32'h0);
        dat_a = 16'h0007;
        step();
        chk("mid_hold2_len", 32'(len_a), 32'h0);
        step();
        chk("mid_hold3_len", 32'(len_a), 32'h0);
        step();
        chk("mid_idle_len",  32'(len_a), 32'h0);
        chk("mid_idle_busy", 32'(busy_a), 32'h0);
        step();
        req_a = 4'b0000;
        chk("mid_load_len",  32'(len_a),  32'h1);
        chk("mid_load_ldat", 32'(ldat_a), 32'h7);
        chk("mid_load_ack",  32'(ack_a),  32'b0001);

        // Async reset mid-HOLD on HOLD_CYCLES=10; ptr must come back to 0
        req_c = 4'b0001; dat_c = 16'h0009;
        step();
        chk("ar_load_ack", 32'(ack_c), 32'b0001);
        req_c = 4'b0000;
        step();
        step();
        chk("ar_hold_busy",  32'(busy_c),  32'h1);
        chk("ar_hold_grant", 32'(grant_c), 32'b0001);
        #2 rst = 1'b1;
        #1;
        chk("ar_async_busy",  32'(busy_c),  32'h0);
        chk("ar_async_grant", 32'(grant_c), 32'h0);
        chk("ar_async_ldat",  32'(ldat_c),  32'h0);
        step();
        rst = 1'b0;
        step();
        chk("ar_rel_len0", 32'(len_c), 32'h0);
        step();
        chk("ar_rel_len1", 32'(len_c), 32'h0);
        req_c = 4'b0011; dat_c = 16'h00C6;
        step();
        chk("ar_ptr_ack",  32'(ack_c),  32'b0001);
        chk("ar_ptr_ldat", 32'(ldat_c), 32'h6);
        req_c = 4'b0000;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
